// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-setting sequencer: state codes (also used by
// the display mux), field limits, mode encodings and the edit-time payload.
package time_set_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MINSEC_W = 6;
  localparam int unsigned TO_W     = 8;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'b000;
  localparam logic [STATE_W-1:0] ST_SET_HOUR = 3'b001;
  localparam logic [STATE_W-1:0] ST_SET_MIN  = 3'b010;
  localparam logic [STATE_W-1:0] ST_SET_SEC  = 3'b011;
  localparam logic [STATE_W-1:0] ST_COMMIT   = 3'b100;

  localparam logic [HOUR_W-1:0]   HOUR_MAX   = 5'd23;
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

  localparam logic [1:0] MODE_CLOCK     = 2'b00;
  localparam logic [1:0] MODE_ALARM     = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;
  localparam logic [1:0] MODE_TIMER     = 2'b11;

  typedef struct packed {
    logic [HOUR_W-1:0]   hour;
    logic [MINSEC_W-1:0] min;
    logic [MINSEC_W-1:0] sec;
  } hms_t;

  // True for the three field-edit states.
  function automatic logic is_set_state(input logic [STATE_W-1:0] s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
  endfunction

endpackage

// File: rtl/time_set_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up/down register with parallel load.
// Ports: i_clk, i_rst_n (async active-low), i_load/i_load_val (load has
// priority), i_en gates i_inc/i_dec; both inc and dec together is a no-op.
// o_q is the registered value.
module time_set_ctrl_wrap_counter #(
  parameter int unsigned W   = 6,
  parameter logic [W-1:0] MAX = W'(59)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load, else wrap-around step in the requested direction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en && i_inc && !i_dec) begin
      r_q <= (r_q >= MAX) ? '0 : r_q + W'(1);
    end else if (i_en && i_dec && !i_inc) begin
      r_q <= (r_q == '0) ? MAX : r_q - W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: snapshots the running time on a set request in clock
// mode, steps through hour/minute/second edit fields with inc/dec wrap-around,
// blinks the selected field and issues a one-cycle commit strobe at the end.
// Ports: clk, reset (async active-low), mode_sel, set/inc/dec button pulses,
// tick_1hz, tick_blink, cur_* running time in; edit_* edit registers, commit,
// editing, cstate (state code) and blink_mask ({hour,min,sec}) out.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S  = 30,
  parameter logic [1:0]  CLOCK_MODE = MODE_CLOCK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode_sel,
  input  logic                set_btn,
  input  logic                inc_btn,
  input  logic                dec_btn,
  input  logic                tick_1hz,
  input  logic                tick_blink,
  input  logic [HOUR_W-1:0]   cur_hour,
  input  logic [MINSEC_W-1:0] cur_min,
  input  logic [MINSEC_W-1:0] cur_sec,
  output logic [HOUR_W-1:0]   edit_hour,
  output logic [MINSEC_W-1:0] edit_min,
  output logic [MINSEC_W-1:0] edit_sec,
  output logic                commit,
  output logic                editing,
  output logic [STATE_W-1:0]  cstate,
  output logic [2:0]          blink_mask
);

  localparam int unsigned TOC_W = TO_W + 1;
  localparam logic [TOC_W-1:0] TIMEOUT_CMP = TOC_W'(TIMEOUT_S);

  logic [STATE_W-1:0] r_state;
  logic [TO_W-1:0]    r_cnt;
  logic               r_phase;
  logic               r_commit;
  logic               r_editing;
  logic [2:0]         r_blink_mask;

  logic [STATE_W-1:0] w_next_state;
  logic [STATE_W-1:0] w_adv_state;
  logic [TO_W-1:0]    w_next_cnt;
  logic               w_next_phase;
  logic [TOC_W-1:0]   w_cnt_inc;
  logic               w_in_clock;
  logic               w_in_set;
  logic               w_btn;
  logic               w_entry;
  logic               w_field_en;
  hms_t               w_edit;

  assign w_in_clock = (mode_sel == CLOCK_MODE);
  assign w_in_set   = is_set_state(r_state);
  assign w_btn      = set_btn | inc_btn | dec_btn;
  // Unused codes behave as IDLE, so entry is allowed from any non-edit, non-commit code.
  assign w_entry    = set_btn && w_in_clock && !w_in_set && (r_state != ST_COMMIT);
  // set_btn takes precedence over inc/dec, and leaving clock mode freezes fields.
  assign w_field_en = w_in_set && w_in_clock && !set_btn;
  assign w_cnt_inc  = TOC_W'(r_cnt) + TOC_W'(1);

  assign w_adv_state = (r_state == ST_SET_HOUR) ? ST_SET_MIN :
                       (r_state == ST_SET_MIN)  ? ST_SET_SEC : ST_COMMIT;

  // Next-state, inactivity counter and blink phase.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_phase = 1'b0;
    case (r_state)
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        w_next_phase = r_phase ^ tick_blink;
        if (!w_in_clock) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (set_btn) begin
          w_next_state = w_adv_state;
          w_next_cnt   = '0;
        end else if (w_btn) begin
          w_next_cnt = '0;
        end else if (tick_1hz) begin
          if (w_cnt_inc >= TIMEOUT_CMP) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = w_cnt_inc[TO_W-1:0];
          end
        end
        if (!is_set_state(w_next_state)) begin
          w_next_phase = 1'b0;
        end
      end
      ST_COMMIT: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = w_entry ? ST_SET_HOUR : ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_commit     <= 1'b0;
      r_editing    <= 1'b0;
      r_blink_mask <= 3'b000;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_phase      <= w_next_phase;
      r_commit     <= (w_next_state == ST_COMMIT);
      r_editing    <= is_set_state(w_next_state);
      r_blink_mask <= {w_next_state == ST_SET_HOUR,
                       w_next_state == ST_SET_MIN,
                       w_next_state == ST_SET_SEC} & {3{w_next_phase}};
    end
  end

  time_set_ctrl_wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_entry),
    .i_load_val (cur_hour),
    .i_en       (w_field_en && (r_state == ST_SET_HOUR)),
    .i_inc      (inc_btn),
    .i_dec      (dec_btn),
    .o_q        (w_edit.hour)
  );

  time_set_ctrl_wrap_counter #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_min (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_entry),
    .i_load_val (cur_min),
    .i_en       (w_field_en && (r_state == ST_SET_MIN)),
    .i_inc      (inc_btn),
    .i_dec      (dec_btn),
    .o_q        (w_edit.min)
  );

  time_set_ctrl_wrap_counter #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_sec (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_entry),
    .i_load_val (cur_sec),
    .i_en       (w_field_en && (r_state == ST_SET_SEC)),
    .i_inc      (inc_btn),
    .i_dec      (dec_btn),
    .o_q        (w_edit.sec)
  );

  assign edit_hour  = w_edit.hour;
  assign edit_min   = w_edit.min;
  assign edit_sec   = w_edit.sec;
  assign commit     = r_commit;
  assign editing    = r_editing;
  assign cstate     = r_state;
  assign blink_mask = r_blink_mask;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed stimulus, an abstract behavioural model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_time_set_ctrl;
  import time_set_ctrl_pkg::*;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       set_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic       tick_1hz = 1'b0, tick_blink = 1'b0;
  logic [4:0] cur_hour = 5'd13;
  logic [5:0] cur_min = 6'd45, cur_sec = 6'd7;
  logic [4:0] edit_hour;
  logic [5:0] edit_min, edit_sec;
  logic       commit, editing;
  logic [2:0] cstate, blink_mask;

  int checks = 0;
  int failures = 0;

  time_set_ctrl #(.TIMEOUT_S(TO), .CLOCK_MODE(2'b00)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel),
    .set_btn(set_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .tick_1hz(tick_1hz), .tick_blink(tick_blink),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
    .commit(commit), .editing(editing), .cstate(cstate), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position 0 = idle, 1..3 = editing hour/min/sec, 4 = commit cycle.
  int m_pos, m_h, m_m, m_s, m_cnt, m_ph;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_ph = 0;
    end else if (m_pos >= 1 && m_pos <= 3) begin
      if (mode_sel != 2'b00) begin
        m_pos = 0; m_cnt = 0; m_ph = 0;
      end else if (set_btn) begin
        m_pos = m_pos + 1; m_cnt = 0;
        m_ph = (m_pos <= 3) ? (m_ph ^ int'(tick_blink)) : 0;
      end else begin
        if (inc_btn && !dec_btn) begin
          if (m_pos == 1) m_h = (m_h + 1) % 24;
          if (m_pos == 2) m_m = (m_m + 1) % 60;
          if (m_pos == 3) m_s = (m_s + 1) % 60;
        end else if (dec_btn && !inc_btn) begin
          if (m_pos == 1) m_h = (m_h + 23) % 24;
          if (m_pos == 2) m_m = (m_m + 59) % 60;
          if (m_pos == 3) m_s = (m_s + 59) % 60;
        end
        if (inc_btn || dec_btn) m_cnt = 0;
        else if (tick_1hz) m_cnt = m_cnt + 1;
        if (m_cnt >= TO) begin
          m_pos = 0; m_cnt = 0; m_ph = 0;
        end else begin
          m_ph = m_ph ^ int'(tick_blink);
        end
      end
    end else if (m_pos == 4) begin
      m_pos = 0; m_ph = 0;
    end else if (set_btn && mode_sel == 2'b00) begin
      m_pos = 1; m_cnt = 0; m_ph = 0;
      m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int exp_mask;
    exp_mask = (m_pos >= 1 && m_pos <= 3 && m_ph != 0) ? (4 >> (m_pos - 1)) : 0;
    chk("m_cstate", int'(cstate), m_pos);
    chk("m_editing", int'(editing), (m_pos >= 1 && m_pos <= 3) ? 1 : 0);
    chk("m_commit", int'(commit), (m_pos == 4) ? 1 : 0);
    chk("m_blink", int'(blink_mask), exp_mask);
    chk("m_hour", int'(edit_hour), m_h);
    chk("m_min", int'(edit_min), m_m);
    chk("m_sec", int'(edit_sec), m_s);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic i, input logic d,
                       input logic t, input logic b);
    set_btn = s; inc_btn = i; dec_btn = d; tick_1hz = t; tick_blink = b;
    step();
    set_btn = 0; inc_btn = 0; dec_btn = 0; tick_1hz = 0; tick_blink = 0;
  endtask

  initial begin
    int commit_cycles;
    step(); step();
    chk("rst_cstate", int'(cstate), 0);
    chk("rst_hour", int'(edit_hour), 0);
    chk("rst_commit", int'(commit), 0);
    reset = 1'b1;
    step();

    // Entry and commit at 13:45:07.
    pulse(1, 0, 0, 0, 0);
    chk("entry_cstate", int'(cstate), 1);
    chk("entry_hour", int'(edit_hour), 13);
    chk("entry_min", int'(edit_min), 45);
    chk("entry_sec", int'(edit_sec), 7);
    pulse(1, 0, 0, 0, 0);
    chk("adv_min", int'(cstate), 2);
    pulse(1, 0, 0, 0, 0);
    chk("adv_sec", int'(cstate), 3);
    pulse(1, 0, 0, 0, 0);
    chk("commit_state", int'(cstate), 4);
    chk("commit_hi", int'(commit), 1);
    commit_cycles = int'(commit);
    step();
    commit_cycles += int'(commit);
    chk("commit_once", commit_cycles, 1);
    chk("post_commit_idle", int'(cstate), 0);
    chk("post_commit_hold", int'(edit_sec), 7);

    // Wrap arithmetic from 23:00:00.
    cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd0;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    chk("hour_inc_wrap", int'(edit_hour), 0);
    pulse(0, 0, 1, 0, 0);
    chk("hour_dec_wrap", int'(edit_hour), 23);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    chk("min_dec_wrap", int'(edit_min), 59);
    pulse(0, 1, 1, 0, 0);
    chk("inc_dec_same", int'(edit_min), 59);

    // Mode abort while editing minutes, then set ignored outside clock mode.
    mode_sel = 2'b01;
    step();
    chk("abort_state", int'(cstate), 0);
    chk("abort_commit", int'(commit), 0);
    chk("abort_mask", int'(blink_mask), 0);
    chk("abort_hold", int'(edit_min), 59);
    pulse(1, 0, 0, 0, 0);
    chk("set_other_mode", int'(cstate), 0);
    mode_sel = 2'b00;
    step();

    // Timeout after three idle ticks.
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    chk("to_before", int'(cstate), 1);
    pulse(0, 0, 0, 1, 0);
    chk("to_idle", int'(cstate), 0);
    chk("to_nocommit", int'(commit), 0);
    chk("to_hold", int'(edit_hour), 10);

    // Activity between tick 2 and 3 restarts the count.
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 1, 0, 0, 0);
    chk("to_inc", int'(edit_hour), 11);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    chk("to_restart", int'(cstate), 1);
    pulse(0, 0, 0, 1, 0);
    chk("to_restart_idle", int'(cstate), 0);

    // Blink sequence in SET_SEC, then set+inc commits without changing sec.
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk("blink_start", int'(blink_mask), 0);
    pulse(0, 0, 0, 0, 1);
    chk("blink_1", int'(blink_mask), 1);
    pulse(0, 0, 0, 0, 1);
    chk("blink_2", int'(blink_mask), 0);
    pulse(0, 0, 0, 0, 1);
    chk("blink_3", int'(blink_mask), 1);
    pulse(0, 0, 0, 0, 1);
    chk("blink_4", int'(blink_mask), 0);
    pulse(1, 1, 0, 0, 0);
    chk("set_wins_state", int'(cstate), 4);
    chk("set_wins_sec", int'(edit_sec), 30);
    step();

    // Asynchronous reset mid-edit.
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    chk("pre_reset_hour", int'(edit_hour), 12);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", int'(cstate), 0);
    chk("async_hour", int'(edit_hour), 0);
    chk("async_commit", int'(commit), 0);
    chk("async_editing", int'(editing), 0);
    step();
    reset = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
